// File: rtl/fifo_tx_drainer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_tx_drainer_pkg                                    |
// | Description : Shared FSM state encoding and width helper for the     |
// |               FIFO-to-UART drainer.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fifo_tx_drainer_pkg;

  localparam logic [2:0] C_ST_IDLE    = 3'd0;
  localparam logic [2:0] C_ST_FETCH   = 3'd1;
  localparam logic [2:0] C_ST_START   = 3'd2;
  localparam logic [2:0] C_ST_WAIT_HI = 3'd3;
  localparam logic [2:0] C_ST_WAIT_LO = 3'd4;
  localparam logic [2:0] C_ST_GAP     = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = C_ST_IDLE,
    S_FETCH   = C_ST_FETCH,
    S_START   = C_ST_START,
    S_WAIT_HI = C_ST_WAIT_HI,
    S_WAIT_LO = C_ST_WAIT_LO,
    S_GAP     = C_ST_GAP
  } state_t;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int f_clog2(input int value);
    int w;
    w = 1;
    while (w < 31 && (1 << w) < value) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_tx_drainer_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : drainer_timer                                          |
// | Description : Loadable down-counter with a zero flag, shared by the  |
// |               handshake-timeout and inter-frame gap counts.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module drainer_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [WIDTH-1:0] r_cnt;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/fifo_tx_drainer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : fifo_tx_drainer                                        |
// | Description : Pops bytes from a first-word-fall-through FIFO and     |
// |               hands them one at a time to a UART transmitter, with   |
// |               handshake retry and optional inter-frame gap.          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module fifo_tx_drainer
  import fifo_tx_drainer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int GAP_CYCLES = 0,
  parameter int HS_TIMEOUT = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_inc,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] tx_p_data,
  output logic                  tx_data_valid,
  output logic [CNT_WIDTH-1:0]  sent_cnt,
  output logic                  idle
);

  localparam int C_TMR_MAX  = (HS_TIMEOUT > GAP_CYCLES) ? HS_TIMEOUT : GAP_CYCLES;
  localparam int C_TMR_W    = f_clog2(C_TMR_MAX);
  // WAIT_HI spends HS_TIMEOUT-1 cycles before re-pulsing, so the retry
  // VALID lands HS_TIMEOUT+1 cycles after the previous one.
  localparam int C_HS_LOAD  = (HS_TIMEOUT > 2) ? HS_TIMEOUT - 2 : 0;
  localparam int C_GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_pop;
  logic                   w_pulse;
  logic                   w_frame_done;
  logic                   w_tmr_load;
  logic                   w_tmr_dec;
  logic                   w_tmr_done;
  logic [C_TMR_W-1:0]     w_tmr_val;

  logic                   r_rd_inc;
  logic                   r_valid;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [CNT_WIDTH-1:0]   r_sent;
  logic                   r_idle;

  drainer_timer #(
    .WIDTH (C_TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_done     (w_tmr_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the per-transition strobes that drive the outputs and timer.
  always_comb begin
    w_next       = r_state;
    w_pop        = 1'b0;
    w_pulse      = 1'b0;
    w_frame_done = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_dec    = 1'b0;
    w_tmr_val    = '0;
    case (r_state)
      S_IDLE: begin
        if (en && !fifo_empty && !tx_busy) begin
          w_next = S_FETCH;
          w_pop  = 1'b1;
        end
      end
      S_FETCH: begin
        w_next  = S_START;
        w_pulse = 1'b1;
      end
      S_START: begin
        w_next     = S_WAIT_HI;
        w_tmr_load = 1'b1;
        w_tmr_val  = C_TMR_W'(C_HS_LOAD);
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          w_next = S_WAIT_LO;
        end else if (w_tmr_done) begin
          // Re-pulse VALID with the byte already held; no second pop.
          w_next = S_FETCH;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          w_frame_done = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_next     = S_GAP;
            w_tmr_load = 1'b1;
            w_tmr_val  = C_TMR_W'(C_GAP_LOAD);
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_GAP: begin
        if (w_tmr_done) begin
          w_next = S_IDLE;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Registered outputs: pop/valid strobes, held byte, frame counter, idle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_inc <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_sent   <= '0;
      r_idle   <= 1'b1;
    end else begin
      r_rd_inc <= w_pop;
      r_valid  <= w_pulse;
      if (w_pop) begin
        r_data <= fifo_rd_data;
      end
      if (w_frame_done) begin
        r_sent <= r_sent + CNT_WIDTH'(1);
      end
      r_idle <= (w_next == S_IDLE);
    end
  end

  assign fifo_rd_inc   = r_rd_inc;
  assign tx_data_valid = r_valid;
  assign tx_p_data     = r_data;
  assign sent_cnt      = r_sent;
  assign idle          = r_idle;

endmodule
`default_nettype wire

// File: tb/tb_fifo_tx_drainer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_fifo_tx_drainer                                     |
// | Description : Scoreboard bench for fifo_tx_drainer with FIFO and     |
// |               UART behavioural models and randomized traffic.        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_fifo_tx_drainer;

  localparam int DW  = 8;
  localparam int GAP = 3;
  localparam int HS  = 16;
  localparam int CW  = 2;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_inc;
  logic          tx_busy;
  logic [DW-1:0] tx_p_data;
  logic          tx_data_valid;
  logic [CW-1:0] sent_cnt;
  logic          idle;

  fifo_tx_drainer #(
    .DATA_WIDTH (DW),
    .GAP_CYCLES (GAP),
    .HS_TIMEOUT (HS),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .fifo_empty    (fifo_empty),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_inc   (fifo_rd_inc),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_data_valid (tx_data_valid),
    .sent_cnt      (sent_cnt),
    .idle          (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  int busy_left  = 0;
  int busy_rises = 0;
  bit ignore_next = 1'b0;
  int tally = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push_byte(input logic [DW-1:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    drive_fifo();
  endtask

  // One cycle of the environment: FIFO pops, UART frame timing.
  task automatic tick();
    @(negedge clk);
    if (rst_n && fifo_rd_inc && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!rst_n) begin
      busy_left = 0;
      tx_busy   = 1'b0;
    end else if (tx_busy) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end else if (tx_data_valid) begin
      if (ignore_next) begin
        ignore_next = 1'b0;
      end else begin
        tx_busy   = 1'b1;
        busy_left = $urandom_range(2, 10);
        busy_rises++;
      end
    end
    drive_fifo();
  endtask

  task automatic wait_rises(input int target);
    int k = 0;
    while (busy_rises < target && k < 3000) begin
      tick();
      k++;
    end
    check("rise_wait", 64'(busy_rises >= target), 64'd1);
  endtask

  task automatic wait_drain();
    int k = 0;
    en = 1'b1;
    while (!(fifo_q.size() == 0 && idle && !tx_busy) && k < 5000) begin
      tick();
      k++;
    end
    check("drain_timeout", 64'(k < 5000), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_inc"}, 64'(fifo_rd_inc), 64'd0);
    check({tag, "_valid"},  64'(tx_data_valid), 64'd0);
    check({tag, "_pdata"},  64'(tx_p_data), 64'd0);
    check({tag, "_sent"},   64'(sent_cnt), 64'd0);
    check({tag, "_idle"},   64'(idle), 64'd1);
  endtask

  // Stimulus.
  initial begin
    int base;
    rst_n = 1'b0;
    en = 1'b0;
    tx_busy = 1'b0;
    drive_fifo();
    repeat (3) tick();
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) tick();

    // Single byte.
    push_byte(8'hA5);
    wait_drain();
    tally++;
    check("single_sent", 64'(sent_cnt), 64'(tally % (1 << CW)));
    check("single_idle", 64'(idle), 64'd1);
    check("single_pdata", 64'(tx_p_data), 64'hA5);

    // Burst 0x01..0x08.
    for (int i = 1; i <= 8; i++) push_byte(DW'(i));
    wait_drain();
    tally += 8;
    check("burst_sent", 64'(sent_cnt), 64'(tally % (1 << CW)));

    // Handshake timeout: UART ignores the first VALID.
    ignore_next = 1'b1;
    push_byte(DW'($urandom_range(0, 255)));
    wait_drain();
    tally++;
    check("timeout_sent", 64'(sent_cnt), 64'(tally % (1 << CW)));

    // EN drop during byte 2 of 4.
    base = busy_rises;
    for (int i = 0; i < 4; i++) push_byte(DW'(8'h40 + i));
    en = 1'b1;
    wait_rises(base + 2);
    en = 1'b0;
    repeat (25) tick();
    tally += 2;
    check("endrop_left", 64'(fifo_q.size()), 64'd2);
    check("endrop_sent", 64'(sent_cnt), 64'(tally % (1 << CW)));
    check("endrop_idle", 64'(idle), 64'd1);
    wait_drain();
    tally += 2;
    check("enresume_sent", 64'(sent_cnt), 64'(tally % (1 << CW)));

    // Asynchronous reset while the second byte is in WAIT_LO.
    base = busy_rises;
    for (int i = 0; i < 3; i++) push_byte(DW'(8'h70 + i));
    wait_rises(base + 2);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    repeat (2) tick();
    rst_n = 1'b1;
    wait_drain();
    tally = 1;
    check("postrst_sent", 64'(sent_cnt), 64'(tally));
    check("postrst_pdata", 64'(tx_p_data), 64'h72);

    // Randomized traffic with EN toggling and occasional ignored VALIDs.
    for (int n = 0; n < 40; ) begin
      tick();
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 1) == 0) begin
        push_byte(DW'($urandom_range(0, 255)));
        n++;
      end
      if ($urandom_range(0, 49) == 0) ignore_next = 1'b1;
    end
    wait_drain();
    repeat (5) tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("final_idle", 64'(idle), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Monitor: pops expected bytes on each FIFO pop and checks everything the DUT presents.
  initial begin
    int cyc = 0;
    int model_cnt = 0;
    logic [DW-1:0] cur_exp = '0;
    bit have_cur = 1'b0;
    bit in_flight = 1'b0;
    bit have_valid = 1'b0;
    bit acked = 1'b0;
    int last_valid = 0;
    int gcnt = 0;
    bit prev_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        model_cnt = 0;
        have_cur = 1'b0;
        in_flight = 1'b0;
        have_valid = 1'b0;
        gcnt = 0;
        prev_busy = 1'b0;
      end else begin
        if (fifo_rd_inc) begin
          check("pop_guard", {61'd0, fifo_empty, en, tx_busy}, 64'b010);
          check("double_pop", 64'(in_flight), 64'd0);
          check("pop_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
          have_cur = 1'b1;
          in_flight = 1'b1;
          have_valid = 1'b0;
        end
        if (tx_data_valid) begin
          check("valid_data", {55'd0, have_cur, tx_p_data}, {55'd0, 1'b1, cur_exp});
          if (have_valid && !acked)
            check("retry_spacing", 64'(cyc - last_valid), 64'(HS + 1));
          last_valid = cyc;
          have_valid = 1'b1;
          acked = 1'b0;
        end
        if (tx_busy && !prev_busy) acked = 1'b1;
        if (tx_busy && have_cur) check("hold_pdata", 64'(tx_p_data), 64'(cur_exp));
        if (!tx_busy && prev_busy) begin
          model_cnt = (model_cnt + 1) % (1 << CW);
          check("sent_cnt", 64'(sent_cnt), 64'(model_cnt));
          in_flight = 1'b0;
          if (GAP > 0) begin
            check("gap_enter", 64'(idle), 64'd0);
            gcnt = 1;
          end else begin
            check("frame_idle", 64'(idle), 64'd1);
          end
        end else if (gcnt > 0) begin
          check("gap_nopop", 64'(fifo_rd_inc), 64'd0);
          if (gcnt < GAP) begin
            check("gap_busy", 64'(idle), 64'd0);
            gcnt++;
          end else begin
            check("gap_exit", 64'(idle), 64'd1);
            gcnt = 0;
          end
        end
        prev_busy = tx_busy;
      end
    end
  end

endmodule
`default_nettype wire
